// File: rtl/seq_alu_pkg.sv
// Shared op-code constants and FSM state type for the sequential ALU
// and for the control unit that drives it.
package alu_pkg;
   localparam logic [3:0] OP_OR   = 4'd0;
   localparam logic [3:0] OP_AND  = 4'd1;
   localparam logic [3:0] OP_NOT  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_SHRA = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_ROR  = 4'd8;
   localparam logic [3:0] OP_ROL  = 4'd9;
   localparam logic [3:0] OP_NEG  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;
endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the register-file read ports, the ALU
// and the Z/HI/LO capture registers.
interface seq_alu_if #(parameter int WIDTH = 32);
   logic                   start;
   logic [3:0]             op;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic [2*WIDTH-1:0]     result;
   logic                   done;
   logic                   busy;
   logic                   div_by_zero;

   modport master (output start, op, a, b,
                   input  result, done, busy, div_by_zero);
   modport slave  (input  start, op, a, b,
                   output result, done, busy, div_by_zero);
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iteration engine shared by signed multiply (radix-2 Booth) and signed
// divide (restoring on magnitudes, signs fixed up on the final step).
module seq_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 clear_n,
   input  logic                 load,
   input  logic                 load_div,
   input  logic                 step,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 last,
   output logic [2*WIDTH-1:0]   value
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   hi, hi_nxt;
   logic [WIDTH-1:0] lo, lo_nxt;
   logic             qm1, qm1_nxt;
   logic [WIDTH-1:0] m;
   logic             div_mode, neg_q, neg_r;
   logic [WIDTH:0]   m_ext, booth_sum, shifted, trial;
   logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;

   assign last = (cnt == CW'(1));

   always_comb begin
      a_mag = a[WIDTH-1] ? -a : a;
      b_mag = b[WIDTH-1] ? -b : b;
      // hi carries one guard bit so Booth add/sub of MIN never overflows
      m_ext = {m[WIDTH-1] & ~div_mode, m};
      case ({lo[0], qm1})
         2'b01:   booth_sum = hi + m_ext;
         2'b10:   booth_sum = hi - m_ext;
         default: booth_sum = hi;
      endcase
      shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
      trial   = shifted - m_ext;
      if (div_mode) begin
         qm1_nxt = qm1;
         if (!trial[WIDTH]) begin
            hi_nxt = trial;
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = shifted;
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         hi_nxt  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
         lo_nxt  = {booth_sum[0], lo[WIDTH-1:1]};
         qm1_nxt = lo[0];
      end
      quo_fix = neg_q ? -lo_nxt : lo_nxt;
      rem_fix = neg_r ? -hi_nxt[WIDTH-1:0] : hi_nxt[WIDTH-1:0];
      value   = div_mode ? {rem_fix, quo_fix} : {hi_nxt[WIDTH-1:0], lo_nxt};
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         qm1      <= 1'b0;
         m        <= '0;
         div_mode <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (load) begin
         cnt      <= CW'(WIDTH);
         hi       <= '0;
         qm1      <= 1'b0;
         div_mode <= load_div;
         if (load_div) begin
            lo    <= a_mag;
            m     <= b_mag;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r <= a[WIDTH-1];
         end else begin
            lo    <= b;
            m     <= a;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
         end
      end else if (step && cnt != '0) begin
         cnt <= cnt - CW'(1);
         hi  <= hi_nxt;
         lo  <= lo_nxt;
         qm1 <= qm1_nxt;
      end
   end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/shift ops plus iterative MUL/DIV.
//   state  | meaning
//   S_IDLE | accepts start; simple ops and DIV-by-0 complete here
//   S_MUL  | Booth multiply iterating, busy
//   S_DIV  | restoring divide iterating, busy
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clock,
   input  logic     clear_n,
   seq_alu_if.slave bus
);
   localparam int SW = $clog2(WIDTH);

   state_t               state, state_nxt;
   logic [2*WIDTH-1:0]   result, result_nxt, md_value;
   logic                 done, done_nxt, dbz, dbz_nxt;
   logic                 load, load_div, last, b_zero;
   logic [SW-1:0]        sh;
   logic [2*WIDTH-1:0]   rot_r, rot_l;
   logic [WIDTH-1:0]     simple;

   assign bus.result      = result;
   assign bus.done        = done;
   assign bus.busy        = (state != S_IDLE);
   assign bus.div_by_zero = dbz;
   assign b_zero          = (bus.b == '0);

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock    (clock),
      .clear_n  (clear_n),
      .load     (load),
      .load_div (load_div),
      .step     (state != S_IDLE),
      .a        (bus.a),
      .b        (bus.b),
      .last     (last),
      .value    (md_value)
   );

   always_comb begin
      sh    = bus.b[SW-1:0];
      rot_r = {bus.a, bus.a} >> sh;
      rot_l = {bus.a, bus.a} << sh;
      case (bus.op)
         OP_OR:   simple = bus.a | bus.b;
         OP_AND:  simple = bus.a & bus.b;
         OP_NOT:  simple = ~bus.b;
         OP_ADD:  simple = bus.a + bus.b;
         OP_SUB:  simple = bus.a - bus.b;
         OP_SHR:  simple = bus.a >> sh;
         OP_SHRA: simple = $signed(bus.a) >>> sh;
         OP_SHL:  simple = bus.a << sh;
         OP_ROR:  simple = rot_r[WIDTH-1:0];
         OP_ROL:  simple = rot_l[2*WIDTH-1:WIDTH];
         OP_NEG:  simple = -bus.b;
         default: simple = '0;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      result_nxt = result;
      done_nxt   = 1'b0;
      dbz_nxt    = dbz;
      load       = 1'b0;
      load_div   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.op == OP_MUL) begin
                  load      = 1'b1;
                  state_nxt = S_MUL;
               end else if (bus.op == OP_DIV && !b_zero) begin
                  load      = 1'b1;
                  load_div  = 1'b1;
                  state_nxt = S_DIV;
               end else begin
                  done_nxt   = 1'b1;
                  dbz_nxt    = (bus.op == OP_DIV);
                  result_nxt = (bus.op == OP_DIV) ? {bus.a, {WIDTH{1'b1}}}
                                                  : {{WIDTH{1'b0}}, simple};
               end
            end
         end
         S_MUL, S_DIV: begin
            if (last) begin
               state_nxt  = S_IDLE;
               done_nxt   = 1'b1;
               dbz_nxt    = 1'b0;
               result_nxt = md_value;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state  <= S_IDLE;
         result <= '0;
         done   <= 1'b0;
         dbz    <= 1'b0;
      end else begin
         state  <= state_nxt;
         result <= result_nxt;
         done   <= done_nxt;
         dbz    <= dbz_nxt;
      end
   end
endmodule
